// File: rtl/fpga_rst_seq.sv
// Reset sequencer for the FPGA top level: debounces the board button, merges the VIO reset,
// waits for PLL lock, pulses the MIG reset, waits for calibration (with retries), then releases the SoC.
module fpga_rst_seq #(
    parameter int unsigned DebounceCycles = 1000,
    parameter int unsigned HoldCycles     = 64,
    parameter int unsigned TimeoutCycles  = 5000000,
    parameter int unsigned MaxRetries     = 3,
    parameter bit          UseDram        = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_i,
    input  logic       vio_rst_i,
    input  logic       pll_locked_i,
    input  logic       dram_calib_done_i,
    input  logic       test_mode_i,
    input  logic [1:0] boot_mode_i,
    output logic       dram_rst_o,
    output logic       soc_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       calib_timeout_o,
    output logic       fail_o,
    output logic [2:0] state_o
);

    localparam int unsigned CntMax = (HoldCycles > TimeoutCycles) ? HoldCycles : TimeoutCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam int unsigned DebW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

    localparam logic [CntW-1:0]   HoldLast    = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [DebW-1:0]   DebLast     = DebW'(DebounceCycles - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MaxRetries);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        DRAM_RST   = 3'd1,
        WAIT_CALIB = 3'd2,
        SOC_HOLD   = 3'd3,
        RUN        = 3'd4,
        FAIL       = 3'd5
    } state_e;

    logic [1:0] btn_sync, lock_sync, cal_sync;
    logic       btn_s, lock_s, cal_s;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_sync  <= '0;
            lock_sync <= '0;
            cal_sync  <= '0;
        end else begin
            btn_sync  <= {btn_sync[0], btn_rst_i};
            lock_sync <= {lock_sync[0], pll_locked_i};
            cal_sync  <= {cal_sync[0], dram_calib_done_i};
        end
    end

    assign btn_s  = btn_sync[1];
    assign lock_s = lock_sync[1];
    assign cal_s  = cal_sync[1];

    logic [DebW-1:0] deb_cnt;
    logic            deb_level;

    // A new button level is accepted only after DebounceCycles consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (btn_s == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DebLast) begin
            deb_level <= btn_s;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    logic trig;
    assign trig = (test_mode_i ? btn_s : deb_level) | vio_rst_i;

    state_e            state;
    logic [CntW-1:0]   cnt;
    logic [RetryW-1:0] retries;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            retries         <= '0;
            dram_rst_o      <= UseDram;
            soc_rst_no      <= 1'b0;
            boot_mode_o     <= '0;
            calib_timeout_o <= 1'b0;
            fail_o          <= 1'b0;
        end else if (trig || !lock_s) begin
            // Any reset request or loss of lock restarts the whole sequence.
            state      <= WAIT_LOCK;
            cnt        <= '0;
            retries    <= '0;
            dram_rst_o <= UseDram;
            soc_rst_no <= 1'b0;
            fail_o     <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (UseDram) begin
                        state      <= DRAM_RST;
                        dram_rst_o <= UseDram;
                    end else begin
                        state <= SOC_HOLD;
                    end
                end
                DRAM_RST: begin
                    if (cnt == HoldLast) begin
                        state      <= WAIT_CALIB;
                        cnt        <= '0;
                        dram_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_CALIB: begin
                    if (cal_s) begin
                        state <= SOC_HOLD;
                        cnt   <= '0;
                    end else if (cnt == TimeoutLast) begin
                        calib_timeout_o <= 1'b1;
                        cnt             <= '0;
                        if (retries < RetryMax) begin
                            retries    <= retries + 1'b1;
                            state      <= DRAM_RST;
                            dram_rst_o <= UseDram;
                        end else begin
                            state  <= FAIL;
                            fail_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SOC_HOLD: begin
                    if (cnt == HoldLast) begin
                        state       <= RUN;
                        cnt         <= '0;
                        soc_rst_no  <= 1'b1;
                        boot_mode_o <= boot_mode_i;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (UseDram && !cal_s) begin
                        state      <= DRAM_RST;
                        cnt        <= '0;
                        retries    <= '0;
                        soc_rst_no <= 1'b0;
                        dram_rst_o <= UseDram;
                    end
                end
                FAIL: begin
                    cnt <= '0;
                end
                default: begin
                    state      <= WAIT_LOCK;
                    cnt        <= '0;
                    retries    <= '0;
                    dram_rst_o <= UseDram;
                    soc_rst_no <= 1'b0;
                    fail_o     <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Self-checking bench for fpga_rst_seq: directed scenarios plus randomized stimulus
// compared every cycle against a phase/age reference model.
module tb_fpga_rst_seq;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int TO   = 100;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       vio = 1'b0;
    logic       lock = 1'b0;
    logic       cal = 1'b0;
    logic       test_mode = 1'b0;
    logic [1:0] boot = 2'b00;

    logic       dram_rst, soc_rst_n, calib_timeout, fail;
    logic [1:0] boot_out;
    logic [2:0] state;
    logic       nd_dram_rst, nd_soc_rst_n, nd_calib_timeout, nd_fail;
    logic [1:0] nd_boot_out;
    logic [2:0] nd_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fpga_rst_seq #(
        .DebounceCycles(DB), .HoldCycles(HOLD), .TimeoutCycles(TO), .MaxRetries(MAXR), .UseDram(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_rst_i(btn), .vio_rst_i(vio), .pll_locked_i(lock),
        .dram_calib_done_i(cal), .test_mode_i(test_mode), .boot_mode_i(boot),
        .dram_rst_o(dram_rst), .soc_rst_no(soc_rst_n), .boot_mode_o(boot_out),
        .calib_timeout_o(calib_timeout), .fail_o(fail), .state_o(state)
    );

    fpga_rst_seq #(
        .DebounceCycles(DB), .HoldCycles(HOLD), .TimeoutCycles(TO), .MaxRetries(MAXR), .UseDram(1'b0)
    ) dut_nd (
        .clk_i(clk), .rst_i(rst), .btn_rst_i(btn), .vio_rst_i(vio), .pll_locked_i(lock),
        .dram_calib_done_i(cal), .test_mode_i(test_mode), .boot_mode_i(boot),
        .dram_rst_o(nd_dram_rst), .soc_rst_no(nd_soc_rst_n), .boot_mode_o(nd_boot_out),
        .calib_timeout_o(nd_calib_timeout), .fail_o(nd_fail), .state_o(nd_state)
    );

    // Reference model: phase number plus time spent in it; outputs are decoded from the phase.
    int       m_phase = 0;
    int       m_age = 0;
    int       m_retries = 0;
    bit       m_timeout = 1'b0;
    bit [1:0] m_boot = 2'b00;
    bit       m_deb = 1'b0;
    int       m_run = 0;
    bit [1:0] m_btn_h = '0, m_lock_h = '0, m_cal_h = '0;

    always @(posedge clk) begin
        bit bs, ls, cs, trg;
        int nxt;
        bs  = m_btn_h[1];
        ls  = m_lock_h[1];
        cs  = m_cal_h[1];
        trg = (test_mode ? bs : m_deb) | vio;
        if (rst) begin
            m_phase = 0; m_age = 0; m_retries = 0; m_timeout = 0; m_boot = 0;
            m_deb = 0; m_run = 0; m_btn_h = 0; m_lock_h = 0; m_cal_h = 0;
        end else begin
            nxt = m_phase;
            if (trg || !ls) begin
                nxt = 0;
                m_retries = 0;
            end else begin
                case (m_phase)
                    0: nxt = 1;
                    1: if (m_age == HOLD - 1) nxt = 2;
                    2: begin
                        if (cs) nxt = 3;
                        else if (m_age == TO - 1) begin
                            m_timeout = 1;
                            if (m_retries < MAXR) begin m_retries++; nxt = 1; end
                            else nxt = 5;
                        end
                    end
                    3: if (m_age == HOLD - 1) begin m_boot = boot; nxt = 4; end
                    4: if (!cs) begin m_retries = 0; nxt = 1; end
                    default: ;
                endcase
            end
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
            if (bs == m_deb) m_run = 0;
            else if (m_run == DB - 1) begin m_deb = bs; m_run = 0; end
            else m_run++;
            m_btn_h  = {m_btn_h[0], btn};
            m_lock_h = {m_lock_h[0], lock};
            m_cal_h  = {m_cal_h[0], cal};
        end
    end

    bit model_en = 1'b0;
    int fail_prints = 0;

    always @(negedge clk) begin
        if (model_en) begin
            logic [2:0] es;
            logic       ed, esn, ef;
            es  = 3'(m_phase);
            ed  = (m_phase <= 1);
            esn = (m_phase == 4);
            ef  = (m_phase == 5);
            checks++;
            if ({state, dram_rst, soc_rst_n, boot_out, calib_timeout, fail} !==
                {es, ed, esn, m_boot, m_timeout, ef}) begin
                errors++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL model cyc=%0d: got st=%0d dram=%b soc_n=%b boot=%b to=%b fail=%b, expected st=%0d dram=%b soc_n=%b boot=%b to=%b fail=%b",
                             cyc, state, dram_rst, soc_rst_n, boot_out, calib_timeout, fail,
                             es, ed, esn, m_boot, m_timeout, ef);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (state === s) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: state_o=%0d, wanted %0d within %0d cycles", tag, state, s, budget);
        end
    endtask

    task automatic count_timeouts(input int budget, output int n, output int gap,
                                  output int first_to, output int first_flag);
        logic [2:0] prev;
        int         last;
        n = 0; gap = -1; first_to = -1; first_flag = -1; last = -1;
        prev = state;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (prev == 3'd2 && (state == 3'd1 || state == 3'd5)) begin
                n++;
                if (last >= 0) gap = i - last;
                else first_to = i;
                last = i;
            end
            if (first_flag < 0 && calib_timeout === 1'b1) first_flag = i;
            prev = state;
            if (state == 3'd5) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, expected 0", state); end
        checks++; if (dram_rst !== 1'b1) begin errors++; $display("FAIL reset_dram: got %b, expected 1", dram_rst); end
        checks++; if (soc_rst_n !== 1'b0) begin errors++; $display("FAIL reset_soc: got %b, expected 0", soc_rst_n); end
        checks++; if ({boot_out, calib_timeout, fail} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got boot=%b to=%b fail=%b, expected 0", boot_out, calib_timeout, fail);
        end
        checks++; if (nd_dram_rst !== 1'b0) begin errors++; $display("FAIL reset_nodram: got %b, expected 0", nd_dram_rst); end
        model_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        int n_dram, n_hold;
        boot = 2'b10;
        cycles(10);
        lock = 1'b1;
        n_dram = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (state == 3'd1 && dram_rst === 1'b1) n_dram++;
            if (state == 3'd2) break;
        end
        checks++; if (n_dram != HOLD) begin errors++; $display("FAIL pu_dram_len: got %0d, expected %0d", n_dram, HOLD); end
        checks++; if (dram_rst !== 1'b0) begin errors++; $display("FAIL pu_dram_fall: got %b, expected 0", dram_rst); end
        repeat (19) @(posedge clk);
        #1;
        cal = 1'b1;
        n_hold = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (state == 3'd3) n_hold++;
            if (state == 3'd4) break;
        end
        checks++; if (n_hold != HOLD) begin errors++; $display("FAIL pu_hold_len: got %0d, expected %0d", n_hold, HOLD); end
        checks++; if (soc_rst_n !== 1'b1) begin errors++; $display("FAIL pu_soc_release: got %b, expected 1", soc_rst_n); end
        checks++; if (boot_out !== 2'b10) begin errors++; $display("FAIL pu_boot: got %b, expected 10", boot_out); end
        @(posedge clk); #1;
        boot = 2'b01;
        cycles(5);
        @(negedge clk);
        checks++; if (boot_out !== 2'b10) begin errors++; $display("FAIL pu_boot_hold: got %b, expected 10", boot_out); end
    endtask

    task automatic test_button_bounce();
        bit   low_seen;
        logic soc_hist [1:7];
        @(posedge clk); #1;
        low_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                if (soc_rst_n !== 1'b1) low_seen = 1'b1;
                @(posedge clk); #1;
            end
        end
        btn = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (soc_rst_n !== 1'b1) low_seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (low_seen) begin errors++; $display("FAIL bounce_ignored: soc_rst_no dropped, expected steady 1"); end
        btn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            soc_hist[k] = soc_rst_n;
        end
        checks++; if (soc_hist[6] !== 1'b1) begin errors++; $display("FAIL btn_latency6: got %b, expected 1", soc_hist[6]); end
        checks++; if (soc_hist[7] !== 1'b0) begin errors++; $display("FAIL btn_latency7: got %b, expected 0", soc_hist[7]); end
        @(posedge clk); #1;
        btn = 1'b0;
        wait_state(3'd1, 50, "btn_restart_dram");
        wait_state(3'd4, 300, "btn_restart_run");
    endtask

    task automatic test_same_cycle();
        @(posedge clk); #1;
        cal = 1'b0;
        wait_state(3'd2, 50, "sc_enter_calib");
        repeat (97) @(posedge clk);
        #1;
        cal = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL sc_pre: got %0d, expected 2", state); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL sc_cal_wins: got %0d, expected 3", state); end
        checks++; if (calib_timeout !== 1'b0) begin errors++; $display("FAIL sc_no_timeout: got %b, expected 0", calib_timeout); end
        wait_state(3'd4, 50, "sc_run");
    endtask

    task automatic test_calib_timeout();
        int n, gap, first_to, first_flag;
        @(posedge clk); #1;
        checks++; if (calib_timeout !== 1'b0) begin errors++; $display("FAIL to_initial: got %b, expected 0", calib_timeout); end
        cal = 1'b0;
        count_timeouts(700, n, gap, first_to, first_flag);
        checks++; if (n != MAXR + 1) begin errors++; $display("FAIL to_count: got %0d, expected %0d", n, MAXR + 1); end
        checks++; if (gap != TO + HOLD) begin errors++; $display("FAIL to_spacing: got %0d, expected %0d", gap, TO + HOLD); end
        checks++; if (first_flag != first_to || first_to < 0) begin
            errors++; $display("FAIL to_flag_set: flag at %0d, first timeout at %0d", first_flag, first_to);
        end
        checks++; if ({state, fail} !== {3'd5, 1'b1}) begin errors++; $display("FAIL to_fail: got st=%0d fail=%b, expected 5/1", state, fail); end
        @(posedge clk); #1;
        vio = 1'b1;
        @(posedge clk); #1;
        vio = 1'b0;
        @(negedge clk);
        checks++; if ({state, fail} !== {3'd0, 1'b0}) begin errors++; $display("FAIL to_vio_exit: got st=%0d fail=%b, expected 0/0", state, fail); end
        wait_state(3'd2, 50, "to_restart_calib");
        @(posedge clk); #1;
        cal = 1'b1;
        wait_state(3'd4, 100, "to_restart_run");
        checks++; if (calib_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b, expected 1", calib_timeout); end
    endtask

    task automatic test_lock_loss();
        int n, gap, first_to, first_flag, hit_k;
        @(posedge clk); #1;
        cal = 1'b0;
        wait_state(3'd2, 50, "ll_calib");
        wait_state(3'd1, 150, "ll_first_retry");
        wait_state(3'd2, 20, "ll_calib2");
        @(posedge clk); #1;
        lock = 1'b0;
        hit_k = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (hit_k == 0 && state === 3'd0) hit_k = k;
        end
        checks++; if (hit_k == 0) begin errors++; $display("FAIL ll_calib_drop: state %0d, expected 0 within 3 cycles", state); end
        @(posedge clk); #1;
        lock = 1'b1;
        count_timeouts(700, n, gap, first_to, first_flag);
        checks++; if (n != MAXR + 1) begin errors++; $display("FAIL ll_retry_clear: got %0d timeouts, expected %0d", n, MAXR + 1); end
        cal = 1'b1;
        @(posedge clk); #1;
        vio = 1'b1;
        @(posedge clk); #1;
        vio = 1'b0;
        wait_state(3'd4, 100, "ll_run");
        @(posedge clk); #1;
        lock = 1'b0;
        hit_k = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (hit_k == 0 && state === 3'd0) hit_k = k;
        end
        checks++; if (hit_k == 0) begin errors++; $display("FAIL ll_run_drop: state %0d, expected 0 within 3 cycles", state); end
        checks++; if (soc_rst_n !== 1'b0) begin errors++; $display("FAIL ll_run_soc: got %b, expected 0", soc_rst_n); end
        @(posedge clk); #1;
        lock = 1'b1;
        wait_state(3'd4, 100, "ll_run_again");
    endtask

    task automatic test_rst();
        bit nd_dram_hi, nd_bad;
        int nd_hold;
        @(posedge clk); #1;
        vio = 1'b1;
        @(posedge clk); #1;
        vio = 1'b0;
        wait_state(3'd3, 100, "rst_hold");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({state, dram_rst, soc_rst_n, boot_out, calib_timeout, fail} !== {3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rst_hold_values: got st=%0d dram=%b soc_n=%b boot=%b to=%b fail=%b",
                               state, dram_rst, soc_rst_n, boot_out, calib_timeout, fail);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cal = 1'b0;
        wait_state(3'd5, 800, "rst_reach_fail");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({state, dram_rst, soc_rst_n, calib_timeout, fail} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rst_fail_values: got st=%0d dram=%b soc_n=%b to=%b fail=%b",
                               state, dram_rst, soc_rst_n, calib_timeout, fail);
        end
        checks++; if ({nd_state, nd_dram_rst} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL nd_reset: got st=%0d dram=%b, expected 0/0", nd_state, nd_dram_rst);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nd_dram_hi = 1'b0; nd_bad = 1'b0; nd_hold = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nd_dram_rst !== 1'b0) nd_dram_hi = 1'b1;
            if (nd_state == 3'd1 || nd_state == 3'd2) nd_bad = 1'b1;
            if (nd_state == 3'd3) nd_hold++;
            if (nd_state == 3'd4) break;
        end
        checks++; if (nd_dram_hi) begin errors++; $display("FAIL nd_dram_low: dram_rst_o went 1, expected 0"); end
        checks++; if (nd_bad) begin errors++; $display("FAIL nd_skip_dram: visited DRAM states, expected none"); end
        checks++; if (nd_hold != HOLD) begin errors++; $display("FAIL nd_hold_len: got %0d, expected %0d", nd_hold, HOLD); end
        checks++; if ({nd_state, nd_soc_rst_n} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL nd_run: got st=%0d soc_n=%b, expected 4/1", nd_state, nd_soc_rst_n);
        end
    endtask

    task automatic test_random();
        int len;
        bit bouncy;
        for (int seg = 0; seg < 60; seg++) begin
            len       = $urandom_range(300, 1);
            bouncy    = ($urandom_range(9, 0) == 0);
            lock      = ($urandom_range(19, 0) != 0);
            cal       = ($urandom_range(9, 0) < 7);
            vio       = ($urandom_range(29, 0) == 0);
            test_mode = ($urandom_range(4, 0) == 0);
            btn       = ($urandom_range(9, 0) == 0);
            boot      = 2'($urandom);
            rst       = ($urandom_range(39, 0) == 0);
            for (int c = 0; c < len; c++) begin
                if (bouncy) btn = 1'($urandom);
                if (c == 1) begin vio = 1'b0; rst = 1'b0; end
                if ($urandom_range(15, 0) == 0) boot = 2'($urandom);
                @(posedge clk); #1;
            end
        end
        rst = 1'b0; vio = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_button_bounce();
        test_same_cycle();
        test_calib_timeout();
        test_lock_loss();
        test_rst();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
